// File: rtl/bs_axi_packer_if.sv
// Byte-stream in / AXI write-word out bundle for bs_axi_packer.
//
// Handshake rules:
//   bs_val_i/bs_dat_i : one byte per cycle when bs_val_i=1. There is no ready,
//                       so the producer is never stalled.
//   wr_val_o/wr_rdy_i : a word transfers on every rising clk edge where both
//                       are 1. While wr_val_o=1 and wr_rdy_i=0, wr_dat_o and
//                       wr_be_o stay stable. wr_val_o never depends on wr_rdy_i.
interface bs_axi_packer_if #(
  parameter int AXI_DW = 512
) ();
  localparam int NB = AXI_DW / 8;

  logic              bs_val_i;
  logic [7:0]        bs_dat_i;
  logic              wr_val_o;
  logic [AXI_DW-1:0] wr_dat_o;
  logic [NB-1:0]     wr_be_o;
  logic              wr_rdy_i;

  // The packer side.
  modport master (
    input  bs_val_i, bs_dat_i, wr_rdy_i,
    output wr_val_o, wr_dat_o, wr_be_o
  );

  // The environment side: byte source plus write sink.
  modport slave (
    output bs_val_i, bs_dat_i, wr_rdy_i,
    input  wr_val_o, wr_dat_o, wr_be_o
  );
endinterface

// File: rtl/bs_axi_packer.sv
// Packs the reversed byte stream into AXI_DW-wide words with byte enables.
// Finished words pass through a 2-entry queue so that short write stalls do
// not lose data. A flush emits any partial word and waits for the queue to
// drain before it pulses done_o.
module bs_axi_packer #(
  parameter int AXI_DW = 512,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sys_start_i,
  input  logic                 flush_i,
  bs_axi_packer_if.master      bus,
  output logic [CNT_W-1:0]     byte_cnt_o,
  output logic                 ovf_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);
  localparam int NB    = AXI_DW / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [AXI_DW-1:0] fill_dat;
  logic [NB-1:0]     fill_be;
  logic [AXI_DW-1:0] new_dat;
  logic [NB-1:0]     new_be;

  logic [AXI_DW-1:0] q_dat [2];
  logic [NB-1:0]     q_be  [2];
  logic [1:0]        q_cnt;
  logic              rd_ptr, wr_ptr;

  logic byte_in, word_full, flush_push, push, pop;
  logic q_empty, q_full, q_wr_en, drop, drain_done;

  assign byte_in    = (state == FILL) && bus.bs_val_i;
  assign word_full  = byte_in && (idx == IDX_W'(NB - 1));
  // A partial word goes out only if it holds at least one byte and the same
  // byte did not already complete a full word.
  assign flush_push = (state == FILL) && flush_i && !word_full &&
                      (byte_in || (idx != '0));
  assign push       = word_full || flush_push;
  assign q_empty    = (q_cnt == 2'd0);
  assign q_full     = (q_cnt == 2'd2);
  assign pop        = !q_empty && bus.wr_rdy_i;
  assign q_wr_en    = push && (!q_full || pop);
  assign drop       = push && q_full && !pop;
  assign drain_done = (state == DRAIN) && (q_empty || ((q_cnt == 2'd1) && pop));

  assign done_o       = drain_done;
  assign state_o      = state;
  assign bus.wr_val_o = !q_empty;
  assign bus.wr_dat_o = q_dat[rd_ptr];
  assign bus.wr_be_o  = q_be[rd_ptr];

  // Working word with the incoming byte merged into lane idx.
  always_comb begin
    new_dat = fill_dat;
    new_be  = fill_be;
    for (int i = 0; i < NB; i++) begin
      if (byte_in && (idx == i[IDX_W-1:0])) begin
        new_dat[8*i +: 8] = bus.bs_dat_i;
        new_be[i]         = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sys_start_i) state_nxt = FILL;
      FILL:    if (flush_i)     state_nxt = DRAIN;
      DRAIN:   if (drain_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fill register, lane index, byte counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx        <= '0;
      fill_dat   <= '0;
      fill_be    <= '0;
      byte_cnt_o <= '0;
      ovf_o      <= 1'b0;
    end else if ((state == IDLE) && sys_start_i) begin
      idx        <= '0;
      fill_dat   <= '0;
      fill_be    <= '0;
      byte_cnt_o <= '0;
      ovf_o      <= 1'b0;
    end else if (state == FILL) begin
      if (byte_in) byte_cnt_o <= byte_cnt_o + CNT_W'(1);
      if (word_full || flush_i) begin
        idx      <= '0;
        fill_dat <= '0;
        fill_be  <= '0;
      end else if (byte_in) begin
        idx      <= idx + IDX_W'(1);
        fill_dat <= new_dat;
        fill_be  <= new_be;
      end
      if (drop) ovf_o <= 1'b1;
    end
  end

  // Two-entry word queue; a push into a full queue succeeds when a pop
  // frees the head slot in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        q_dat[i] <= '0;
        q_be[i]  <= '0;
      end
      q_cnt  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (q_wr_en) begin
        q_dat[wr_ptr] <= new_dat;
        q_be[wr_ptr]  <= new_be;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({q_wr_en, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_bs_axi_packer.sv
// Bench for bs_axi_packer: a job-level model builds expected words from the
// byte list, and a compare process checks every output on each negedge.
module tb_bs_axi_packer;
  localparam int AXI_DW = 512;
  localparam int NB     = AXI_DW / 8;
  localparam int CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             sys_start = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] byte_cnt;
  logic             ovf, done;
  logic [1:0]       state_dbg;

  int tests = 0;
  int fails = 0;

  bs_axi_packer_if #(.AXI_DW(AXI_DW)) bus ();

  bs_axi_packer #(.AXI_DW(AXI_DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sys_start_i (sys_start),
    .flush_i     (flush),
    .bus         (bus),
    .byte_cnt_o  (byte_cnt),
    .ovf_o       (ovf),
    .done_o      (done),
    .state_o     (state_dbg)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  task automatic check(string name, logic [AXI_DW-1:0] act, logic [AXI_DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Job mode: 0 idle, 1 collecting bytes, 2 draining.
  logic [AXI_DW-1:0] exp_q[$];
  logic [NB-1:0]     exp_be_q[$];
  logic [7:0]        m_part[$];
  int                m_mode;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_ovf;

  always @(posedge clk or negedge rstn) begin
    logic              m_pop, have;
    logic [AXI_DW-1:0] w;
    logic [NB-1:0]     b;
    if (!rstn) begin
      exp_q.delete();
      exp_be_q.delete();
      m_part.delete();
      m_mode = 0;
      m_cnt  = '0;
      m_ovf  = 1'b0;
    end else begin
      m_pop = (exp_q.size() != 0) && bus.wr_rdy_i;
      have  = 1'b0;
      w     = '0;
      b     = '0;
      case (m_mode)
        0: if (sys_start) begin
          m_mode = 1;
          m_cnt  = '0;
          m_ovf  = 1'b0;
          m_part.delete();
        end
        1: begin
          if (bus.bs_val_i) begin
            m_part.push_back(bus.bs_dat_i);
            m_cnt = m_cnt + 1;
          end
          if (m_part.size() == NB || (flush && m_part.size() > 0)) begin
            for (int k = 0; k < m_part.size(); k++) begin
              w[8*k +: 8] = m_part[k];
              b[k]        = 1'b1;
            end
            have = 1'b1;
            m_part.delete();
          end
          if (flush) m_mode = 2;
        end
        default: if (exp_q.size() == 0 || (exp_q.size() == 1 && m_pop)) m_mode = 0;
      endcase
      if (m_pop) begin
        void'(exp_q.pop_front());
        void'(exp_be_q.pop_front());
      end
      if (have) begin
        if (exp_q.size() < 2) begin
          exp_q.push_back(w);
          exp_be_q.push_back(b);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [AXI_DW-1:0] got_dat[$];
  logic [NB-1:0]     got_be[$];
  int                done_seen = 0;

  always @(negedge clk) begin
    logic exp_done;
    exp_done = (m_mode == 2) &&
               (exp_q.size() == 0 || (exp_q.size() == 1 && bus.wr_rdy_i));
    check("wr_val", bus.wr_val_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("wr_dat", bus.wr_dat_o, exp_q[0]);
      check("wr_be", bus.wr_be_o, exp_be_q[0]);
    end
    check("byte_cnt", byte_cnt, m_cnt);
    check("ovf", ovf, m_ovf);
    check("done", done, exp_done);
    check("state", state_dbg, m_mode[1:0]);
    if (bus.wr_val_o && bus.wr_rdy_i) begin
      got_dat.push_back(bus.wr_dat_o);
      got_be.push_back(bus.wr_be_o);
    end
    if (done) done_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    bus.bs_val_i = 1'b1;
    bus.bs_dat_i = b;
    flush        = fl;
    tick();
    bus.bs_val_i = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic start_job();
    got_dat.delete();
    got_be.delete();
    sys_start = 1'b1;
    tick();
    sys_start = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (state_dbg != 2'd0 && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", n >= budget, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AXI_DW-1:0] w, ref_w;
    logic [NB-1:0]     all_be;
    int                d0;
    all_be = '1;
    bus.bs_val_i = 1'b0;
    bus.bs_dat_i = 8'h00;
    bus.wr_rdy_i = 1'b1;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_wr_val", bus.wr_val_o, 1'b0);
    check("rst_wr_dat", bus.wr_dat_o, '0);
    check("rst_wr_be", bus.wr_be_o, '0);
    check("rst_byte_cnt", byte_cnt, '0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    rstn = 1'b1;
    tick();

    // T1: 64 bytes 0x00..0x3F then flush
    start_job();
    for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
    check("t1_latency_val", bus.wr_val_o, 1'b1);
    d0 = done_seen;
    flush_pulse();
    wait_idle(50);
    check("t1_words", got_dat.size(), 1);
    ref_w = '0;
    for (int k = 0; k < NB; k++) ref_w[8*k +: 8] = 8'(k);
    w = got_dat[0];
    check("t1_word", w, ref_w);
    check("t1_lane63", w[511:504], 8'h3F);
    check("t1_be", got_be[0], all_be);
    check("t1_cnt", byte_cnt, 64);
    check("t1_ovf", ovf, 1'b0);
    check("t1_done_pulses", done_seen - d0, 1);

    // T2: 70 bytes then flush -> full word + 6-byte partial
    start_job();
    for (int i = 0; i < 70; i++) send(8'(i), 1'b0);
    flush_pulse();
    wait_idle(50);
    check("t2_words", got_dat.size(), 2);
    check("t2_be0", got_be[0], all_be);
    w = got_dat[1];
    check("t2_lo", w[47:0], 48'h454443424140);
    check("t2_hi_zero", w[511:48], '0);
    check("t2_be1", got_be[1], 64'h3F);
    check("t2_cnt", byte_cnt, 70);

    // T3: sink stalled for 192 bytes -> third word dropped
    bus.wr_rdy_i = 1'b0;
    start_job();
    for (int i = 0; i < 192; i++) send(8'(i), 1'b0);
    check("t3_ovf", ovf, 1'b1);
    check("t3_val", bus.wr_val_o, 1'b1);
    flush_pulse();
    repeat (4) tick();
    check("t3_stall_state", state_dbg, 2'd2);
    bus.wr_rdy_i = 1'b1;
    wait_idle(50);
    check("t3_words", got_dat.size(), 2);
    w = got_dat[0];
    check("t3_w0_lane63", w[511:504], 8'h3F);
    w = got_dat[1];
    check("t3_w1_lane0", w[7:0], 8'h40);
    check("t3_w1_lane63", w[511:504], 8'h7F);
    check("t3_cnt", byte_cnt, 192);

    // T4: flush coincident with the 64th byte
    start_job();
    d0 = done_seen;
    for (int i = 0; i < 63; i++) send(8'(i + 16), 1'b0);
    send(8'hEE, 1'b1);
    wait_idle(50);
    check("t4_words", got_dat.size(), 1);
    check("t4_be", got_be[0], all_be);
    w = got_dat[0];
    check("t4_lane63", w[511:504], 8'hEE);
    check("t4_done_pulses", done_seen - d0, 1);

    // T5: reset mid-FILL with one word queued
    bus.wr_rdy_i = 1'b0;
    start_job();
    for (int i = 0; i < 69; i++) send(8'(i), 1'b0);
    check("t5_queued", bus.wr_val_o, 1'b1);
    rstn = 1'b0;
    tick();
    check("t5_rst_val", bus.wr_val_o, 1'b0);
    check("t5_rst_dat", bus.wr_dat_o, '0);
    check("t5_rst_be", bus.wr_be_o, '0);
    check("t5_rst_cnt", byte_cnt, '0);
    check("t5_rst_ovf", ovf, 1'b0);
    check("t5_rst_state", state_dbg, 2'd0);
    rstn = 1'b1;
    bus.wr_rdy_i = 1'b1;
    tick();
    start_job();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    flush_pulse();
    wait_idle(50);
    check("t5_words", got_dat.size(), 1);
    w = got_dat[0];
    check("t5_lo", w[23:0], 24'hCCBBAA);
    check("t5_be", got_be[0], 64'h7);
    check("t5_cnt", byte_cnt, 3);

    // T6: start and bytes during DRAIN / IDLE are ignored
    bus.wr_rdy_i = 1'b0;
    start_job();
    for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
    flush_pulse();
    sys_start    = 1'b1;
    bus.bs_val_i = 1'b1;
    bus.bs_dat_i = 8'h55;
    repeat (3) tick();
    sys_start    = 1'b0;
    bus.bs_val_i = 1'b0;
    check("t6_drain_state", state_dbg, 2'd2);
    check("t6_drain_cnt", byte_cnt, 64);
    bus.wr_rdy_i = 1'b1;
    wait_idle(50);
    bus.bs_val_i = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.bs_val_i = 1'b0;
    tick();
    check("t6_idle_state", state_dbg, 2'd0);
    check("t6_idle_cnt", byte_cnt, 64);
    check("t6_idle_val", bus.wr_val_o, 1'b0);
    check("t6_words", got_dat.size(), 1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
